// File: rtl/pcs_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcs_tx_pkg
// Description : Shared XGMII control codes, fixed columns and the state
//               encoding for the PCS TX FIFO read-side sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pcs_tx_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERR   = 8'hFE;

  // Column layout: [71:64] ctrl (bit 64 = lane0), [63:0] data (lane0 = [7:0])
  localparam logic [71:0] IDLE_COL = {8'hFF, {8{XGMII_IDLE}}};
  localparam logic [71:0] ERR_COL  = {8'hFF, {8{XGMII_ERR}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pcs_tx_col_decode.sv
`default_nettype none
// ============================================================================
// Module      : pcs_tx_col_decode
// Description : Combinational decode of one 72-bit XGMII column: START in
//               lane0/lane4, presence of TERM and the lowest lane holding it.
// Revision    : 1.0 - initial release
// ============================================================================
module pcs_tx_col_decode
  import pcs_tx_pkg::*;
(
  input  logic [71:0] rdata,
  output logic        has_start_l0,
  output logic        has_start_l4,
  output logic        has_term,
  output logic [2:0]  term_lane
);

  assign has_start_l0 = rdata[64] && (rdata[7:0]   == XGMII_START);
  assign has_start_l4 = rdata[68] && (rdata[39:32] == XGMII_START);

  // Scan from lane7 down so the lowest TERM lane is the one reported
  always_comb begin
    has_term  = 1'b0;
    term_lane = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rdata[64 + i] && (rdata[8*i +: 8] == XGMII_TERM)) begin
        has_term  = 1'b1;
        term_lane = 3'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pcs_tx_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pcs_tx_fifo_rd_ctrl
// Description : Read-side sequencer for the PCS TX clock-crossing FIFO.
//               Pops columns toward the 64b/66b encoder, inserts idles when
//               empty between frames, turns a mid-frame underrun into one
//               error column and drops the remainder of that frame.
//               Optional statistics counters: PCS_TX_RD_CTRL_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pcs_tx_fifo_rd_ctrl
  import pcs_tx_pkg::*;
#(
  parameter int DSIZE = 72,
  parameter int CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             tx_pause,
  output logic [DSIZE-1:0] tx_col,
  output logic             underrun,
  output logic             frame_active,
  output logic [CNT_W-1:0] underrun_cnt,
  output logic [CNT_W-1:0] idle_ins_cnt
);

  state_t           r_state;
  state_t           w_next_state;
  logic [DSIZE-1:0] r_tx_col;
  logic [DSIZE-1:0] w_next_col;
  logic             r_underrun;
  logic             r_frame_active;
  logic             w_underrun_evt;

  logic             w_start_l0;
  logic             w_start_l4;
  logic             w_term;
  logic [2:0]       w_term_lane;
  logic             w_start_open;
  logic             w_restart;

  pcs_tx_col_decode u_decode (
    .rdata        (rdata),
    .has_start_l0 (w_start_l0),
    .has_start_l4 (w_start_l4),
    .has_term     (w_term),
    .term_lane    (w_term_lane)
  );

  // Frame opens when a START is not closed by a TERM later in the same column
  assign w_start_open = (w_start_l0 && !w_term) ||
                        (w_start_l4 && !(w_term && (w_term_lane > 3'd4)));
  // TERM in the low half followed by a new START in lane4
  assign w_restart    = w_start_l4 && w_term && (w_term_lane < 3'd4);

  assign rinc = ~tx_pause & ~rempty & ~rrst;

  // Next-state and next-column selection; pause holds everything
  always_comb begin
    w_next_state   = r_state;
    w_next_col     = r_tx_col;
    w_underrun_evt = 1'b0;
    if (!tx_pause) begin
      case (r_state)
        ST_IDLE: begin
          if (rempty) begin
            w_next_col = IDLE_COL;
          end else begin
            w_next_col = rdata;
            if (w_start_open) w_next_state = ST_FRAME;
          end
        end
        ST_FRAME: begin
          if (rempty) begin
            w_next_col     = ERR_COL;
            w_underrun_evt = 1'b1;
            w_next_state   = ST_DROP;
          end else begin
            w_next_col = rdata;
            if (w_term && !w_restart) w_next_state = ST_IDLE;
          end
        end
        ST_DROP: begin
          // A frame starting inside the terminating column lost its head
          // to the error, so it is dropped as well.
          w_next_col = IDLE_COL;
          if (!rempty && w_term) begin
            w_next_state = w_restart ? ST_DROP : ST_IDLE;
          end
        end
        default: begin
          w_next_col   = IDLE_COL;
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // State, output column and status registers
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_state        <= ST_IDLE;
      r_tx_col       <= IDLE_COL;
      r_underrun     <= 1'b0;
      r_frame_active <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_tx_col       <= w_next_col;
      r_underrun     <= w_underrun_evt;
      r_frame_active <= (w_next_state == ST_FRAME);
    end
  end

  assign tx_col       = r_tx_col;
  assign underrun     = r_underrun;
  assign frame_active = r_frame_active;

`ifdef PCS_TX_RD_CTRL_STATS_EN
  logic [CNT_W-1:0] r_underrun_cnt;
  logic [CNT_W-1:0] r_idle_ins_cnt;
  logic             w_idle_ins;

  assign w_idle_ins = (r_state == ST_IDLE) && rempty && !tx_pause;

  // Saturating event counters
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_underrun_cnt <= '0;
      r_idle_ins_cnt <= '0;
    end else begin
      if (w_underrun_evt && (r_underrun_cnt != {CNT_W{1'b1}}))
        r_underrun_cnt <= r_underrun_cnt + CNT_W'(1);
      if (w_idle_ins && (r_idle_ins_cnt != {CNT_W{1'b1}}))
        r_idle_ins_cnt <= r_idle_ins_cnt + CNT_W'(1);
    end
  end

  assign underrun_cnt = r_underrun_cnt;
  assign idle_ins_cnt = r_idle_ins_cnt;
`else
  assign underrun_cnt = '0;
  assign idle_ins_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcs_tx_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcs_tx_fifo_rd_ctrl
// Description : Directed self-checking bench for pcs_tx_fifo_rd_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcs_tx_fifo_rd_ctrl;

  localparam logic [71:0] C_IDLE  = {8'hFF, {8{8'h07}}};
  localparam logic [71:0] C_ERR   = {8'hFF, {8{8'hFE}}};
  localparam logic [71:0] C_START = {8'h01, 64'hD5555555_555555FB};
  localparam logic [71:0] C_D1    = {8'h00, 64'h00112233_44556677};
  localparam logic [71:0] C_D2    = {8'h00, 64'h8899AABB_CCDDEEFF};
  localparam logic [71:0] C_TERM3 = {8'hF8, 64'h07070707_FD112233};
  localparam logic [71:0] C_T2S4  = {8'h1C, 64'h555555FB_07FDAABB};

  logic        rclk = 1'b0;
  logic        rrst;
  logic        rempty;
  logic [71:0] rdata;
  logic        rinc;
  logic        tx_pause;
  logic [71:0] tx_col;
  logic        underrun;
  logic        frame_active;
  logic [15:0] underrun_cnt;
  logic [15:0] idle_ins_cnt;

  int n_pass  = 0;
  int n_total = 0;
  int step    = 0;

  pcs_tx_fifo_rd_ctrl #(.DSIZE(72), .CNT_W(16)) dut (
    .rclk         (rclk),
    .rrst         (rrst),
    .rempty       (rempty),
    .rdata        (rdata),
    .rinc         (rinc),
    .tx_pause     (tx_pause),
    .tx_col       (tx_col),
    .underrun     (underrun),
    .frame_active (frame_active),
    .underrun_cnt (underrun_cnt),
    .idle_ins_cnt (idle_ins_cnt)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s step=%0d observed=%h expected=%h", tag, step, obs, exp);
  endtask

  // One clock: drive at negedge, check rinc, then check registered outputs
  task automatic cyc(input logic e, input logic [71:0] d, input logic p,
                     input logic xr, input logic [71:0] xc,
                     input logic xu, input logic xf);
    step++;
    @(negedge rclk);
    rempty   = e;
    rdata    = d;
    tx_pause = p;
    #1 chk("rinc", {71'd0, rinc}, {71'd0, xr});
    @(posedge rclk);
    #1;
    chk("tx_col", tx_col, xc);
    chk("underrun", {71'd0, underrun}, {71'd0, xu});
    chk("frame_active", {71'd0, frame_active}, {71'd0, xf});
  endtask

  task automatic chk_cnt(input int xund, input int xidle);
`ifdef PCS_TX_RD_CTRL_STATS_EN
    chk("underrun_cnt", {56'd0, underrun_cnt}, 72'(xund));
    chk("idle_ins_cnt", {56'd0, idle_ins_cnt}, 72'(xidle));
`else
    chk("underrun_cnt", {56'd0, underrun_cnt}, 72'd0);
    chk("idle_ins_cnt", {56'd0, idle_ins_cnt}, 72'd0);
`endif
  endtask

  initial begin
    rrst     = 1'b1;
    rempty   = 1'b0;
    rdata    = C_D1;
    tx_pause = 1'b0;
    repeat (3) @(posedge rclk);
    #1;
    chk("rst_tx_col", tx_col, C_IDLE);
    chk("rst_underrun", {71'd0, underrun}, 72'd0);
    chk("rst_frame_active", {71'd0, frame_active}, 72'd0);
    chk("rst_rinc", {71'd0, rinc}, 72'd0);
    chk_cnt(0, 0);
    @(negedge rclk);
    rrst   = 1'b0;
    rempty = 1'b1;

    // 1: idle insertion
    for (int i = 0; i < 10; i++) cyc(1, C_D2, 0, 0, C_IDLE, 0, 0);
    chk_cnt(0, 10);

    // 2: clean 4-column frame
    cyc(0, C_START, 0, 1, C_START, 0, 1);
    cyc(0, C_D1,    0, 1, C_D1,    0, 1);
    cyc(0, C_D2,    0, 1, C_D2,    0, 1);
    cyc(0, C_TERM3, 0, 1, C_TERM3, 0, 0);
    cyc(1, C_D1,    0, 0, C_IDLE,  0, 0);
    chk_cnt(0, 11);

    // 3: underrun mid-frame, tail dropped, next frame intact
    cyc(0, C_START, 0, 1, C_START, 0, 1);
    cyc(0, C_D1,    0, 1, C_D1,    0, 1);
    cyc(1, C_D2,    0, 0, C_ERR,   1, 0);
    cyc(1, C_D2,    0, 0, C_IDLE,  0, 0);
    cyc(0, C_D2,    0, 1, C_IDLE,  0, 0);
    cyc(0, C_TERM3, 0, 1, C_IDLE,  0, 0);
    cyc(1, C_D1,    0, 0, C_IDLE,  0, 0);
    chk_cnt(1, 12);
    cyc(0, C_START, 0, 1, C_START, 0, 1);
    cyc(0, C_D1,    0, 1, C_D1,    0, 1);
    cyc(0, C_TERM3, 0, 1, C_TERM3, 0, 0);

    // 4: pause mid-frame freezes output, then resumes
    cyc(0, C_START, 0, 1, C_START, 0, 1);
    cyc(0, C_D1,    0, 1, C_D1,    0, 1);
    cyc(0, C_D2,    1, 0, C_D1,    0, 1);
    cyc(0, C_D2,    1, 0, C_D1,    0, 1);
    cyc(1, C_D2,    1, 0, C_D1,    0, 1);
    cyc(0, C_D2,    0, 1, C_D2,    0, 1);
    cyc(0, C_TERM3, 0, 1, C_TERM3, 0, 0);
    chk_cnt(1, 12);

    // 5a: TERM lane2 + START lane4 inside a frame keeps FRAME
    cyc(0, C_START, 0, 1, C_START, 0, 1);
    cyc(0, C_D1,    0, 1, C_D1,    0, 1);
    cyc(0, C_T2S4,  0, 1, C_T2S4,  0, 1);
    cyc(0, C_D2,    0, 1, C_D2,    0, 1);
    cyc(0, C_TERM3, 0, 1, C_TERM3, 0, 0);
    // 5b: the same column in DROP drops the new frame too
    cyc(0, C_START, 0, 1, C_START, 0, 1);
    cyc(1, C_D1,    0, 0, C_ERR,   1, 0);
    cyc(0, C_T2S4,  0, 1, C_IDLE,  0, 0);
    cyc(0, C_D1,    0, 1, C_IDLE,  0, 0);
    cyc(0, C_TERM3, 0, 1, C_IDLE,  0, 0);
    cyc(0, C_D1,    0, 1, C_D1,    0, 0);
    cyc(1, C_D1,    0, 0, C_IDLE,  0, 0);
    chk_cnt(2, 13);

    // 6: asynchronous reset mid-frame
    cyc(0, C_START, 0, 1, C_START, 0, 1);
    cyc(0, C_D1,    0, 1, C_D1,    0, 1);
    #2 rrst = 1'b1;
    #1;
    step++;
    chk("arst_tx_col", tx_col, C_IDLE);
    chk("arst_frame_active", {71'd0, frame_active}, 72'd0);
    chk("arst_rinc", {71'd0, rinc}, 72'd0);
    chk_cnt(0, 0);
    @(negedge rclk);
    rrst = 1'b0;
    cyc(1, C_D2,    0, 0, C_IDLE,  0, 0);
    cyc(0, C_START, 0, 1, C_START, 0, 1);
    cyc(0, C_TERM3, 0, 1, C_TERM3, 0, 0);
    chk_cnt(0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
